// File: rtl/fpu_int2flt.sv
// Multi-cycle int32 -> binary32 converter (FCVT.S.W / FCVT.S.WU) with valid/ready on both sides.
// Optional inexact flag output out_nx when FPU_INT2FLT_FLAGS_EN is defined.
module fpu_int2flt #(
  parameter int SHIFT_PER_CYCLE = 8
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in,
  input  logic        is_signed,
  input  logic [2:0]  rm,
  output logic        out_valid,
  input  logic        out_ready,
`ifdef FPU_INT2FLT_FLAGS_EN
  output logic        out_nx,
`endif
  output logic [31:0] out
);

  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

  state_t      state, state_nxt;
  logic        sign;
  logic [31:0] mag;
  logic [7:0]  exp;
  logic [2:0]  rm_q;
  logic [31:0] res;
  logic        accept;
  logic        in_sign;
  logic [31:0] in_mag;
  logic [5:0]  shamt;
  logic        ru;

  // Leading zeros within the top SHIFT_PER_CYCLE bits; equals SHIFT_PER_CYCLE when all are zero.
  function automatic logic [5:0] lead_zeros(input logic [31:0] v);
    logic [5:0] n;
    logic       found;
    n     = 6'd0;
    found = 1'b0;
    for (int i = 31; i >= 32 - SHIFT_PER_CYCLE; i--) begin
      if (!found) begin
        if (v[i]) found = 1'b1;
        else      n = n + 6'd1;
      end
    end
    return n;
  endfunction

  function automatic logic round_up(input logic [2:0] mode, input logic neg,
                                    input logic lsb, input logic gb,
                                    input logic rb, input logic sb);
    logic up;
    logic inexact;
    inexact = gb | rb | sb;
    case (mode)
      3'b000:  up = gb & (rb | sb | lsb);
      3'b010:  up = inexact & neg;
      3'b011:  up = inexact & ~neg;
      3'b100:  up = gb;
      default: up = 1'b0;
    endcase
    return up;
  endfunction

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign out       = res;
  assign accept    = in_valid && in_ready && !flush;
  assign in_sign   = is_signed & in[31];
  assign in_mag    = in_sign ? (~in + 32'd1) : in;
  assign shamt     = lead_zeros(mag);
  assign ru        = round_up(rm_q, sign, mag[8], mag[7], mag[6], |mag[5:0]);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = (in_mag == 32'd0) ? DONE : NORM;
      NORM:    if (mag[31]) state_nxt = ROUND;
      ROUND:   state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sign <= 1'b0;
      mag  <= 32'd0;
      exp  <= 8'd0;
      rm_q <= 3'd0;
      res  <= 32'd0;
    end else if (accept) begin
      sign <= in_sign;
      mag  <= in_mag;
      exp  <= 8'd158;
      rm_q <= rm;
      if (in_mag == 32'd0) res <= 32'd0;
    end else if (state == NORM && !mag[31]) begin
      mag <= mag << shamt;
      exp <= exp - {2'b00, shamt};
    end else if (state == ROUND) begin
      // A mantissa carry ripples into the exponent field through the joint add.
      res <= {sign, {exp, mag[30:8]} + {30'd0, ru}};
    end
  end

`ifdef FPU_INT2FLT_FLAGS_EN
  logic nx_q;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                  nx_q <= 1'b0;
    else if (flush)                nx_q <= 1'b0;
    else if (accept)               nx_q <= 1'b0;
    else if (state == ROUND)       nx_q <= mag[7] | mag[6] | (|mag[5:0]);
  end
  assign out_nx = nx_q;
`endif

endmodule
